// File: rtl/ld_shot_sequencer.sv
// -----------------------------------------------------------------------------
// ld_shot_sequencer
//
// Generates the periodic laser-diode start pulse and, aligned to each pulse, a
// capture-enable window for the ADC sample writer. It runs a burst of
// num_shots_i shots, or runs continuously when num_shots_i is 0. Before each
// shot it waits for the capture buffer. It reports progress and completion.
//
// Ports
//   clk           system clock; all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   start_i       single-cycle burst request, ignored while busy
//   abort_i       single-cycle stop request, highest priority
//   num_shots_i   burst length, latched on an accepted start (0 = continuous)
//   buf_rdy_i     capture buffer can take one full shot
//   ld_start_o    laser-diode start pulse
//   cap_en_o      ADC capture window
//   cap_first_o   pulse on the first cycle of each capture window
//   shot_idx_o    0-based index of the current or last shot
//   busy_o        high from an accepted start until the return to idle
//   done_o        one-cycle pulse when a finite burst completes
// -----------------------------------------------------------------------------
module ld_shot_sequencer #(
  parameter int PERIOD    = 1250,
  parameter int PULSE_W   = 6,
  parameter int CAP_DELAY = 20,
  parameter int CAP_LEN   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] num_shots_i,
  input  logic             buf_rdy_i,
  output logic             ld_start_o,
  output logic             cap_en_o,
  output logic             cap_first_o,
  output logic [CNT_W-1:0] shot_idx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int PW = $clog2(PERIOD);

  // Window boundaries, pre-sized to the period counter width.
  localparam logic [PW-1:0] LAST_CNT  = PW'(PERIOD - 1);
  localparam logic [PW-1:0] PULSE_END = PW'(PULSE_W);
  localparam logic [PW-1:0] CAP_START = PW'(CAP_DELAY);
  localparam logic [PW-1:0] CAP_LAST  = PW'(CAP_DELAY + CAP_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RDY = 2'd1,
    S_SHOT     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] shot_idx_q, shot_idx_d;
  logic [CNT_W-1:0] num_shots_q, num_shots_d;
  logic             burst_end_d;

  logic ld_start_q, ld_start_d;
  logic cap_en_q, cap_en_d;
  logic cap_first_q, cap_first_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      period_cnt_q <= '0;
      shot_idx_q   <= '0;
      num_shots_q  <= '0;
      ld_start_q   <= 1'b0;
      cap_en_q     <= 1'b0;
      cap_first_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      shot_idx_q   <= shot_idx_d;
      num_shots_q  <= num_shots_d;
      ld_start_q   <= ld_start_d;
      cap_en_q     <= cap_en_d;
      cap_first_q  <= cap_first_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    shot_idx_d   = shot_idx_q;
    num_shots_d  = num_shots_q;
    burst_end_d  = 1'b0;

    if (abort_i) begin
      state_d      = S_IDLE;
      period_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            num_shots_d  = num_shots_i;
            shot_idx_d   = '0;
            period_cnt_d = '0;
            state_d      = buf_rdy_i ? S_SHOT : S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (buf_rdy_i) begin
            period_cnt_d = '0;
            state_d      = S_SHOT;
          end
        end
        S_SHOT: begin
          if (period_cnt_q == LAST_CNT) begin
            period_cnt_d = '0;
            if ((num_shots_q != '0) && (shot_idx_q == num_shots_q - CNT_W'(1))) begin
              burst_end_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              // Wraps naturally in continuous mode.
              shot_idx_d = shot_idx_q + CNT_W'(1);
              state_d    = buf_rdy_i ? S_SHOT : S_WAIT_RDY;
            end
          end else begin
            period_cnt_d = period_cnt_q + PW'(1);
          end
        end
        default: begin
          state_d      = S_IDLE;
          period_cnt_d = '0;
        end
      endcase
    end
  end

  // Output logic: decoded from the next state so every output is a register
  // that is valid in the same cycle as the period count it describes.
  always_comb begin
    ld_start_d  = 1'b0;
    cap_en_d    = 1'b0;
    cap_first_d = 1'b0;
    busy_d      = (state_d != S_IDLE);
    done_d      = burst_end_d;
    if (state_d == S_SHOT) begin
      ld_start_d  = (period_cnt_d < PULSE_END);
      cap_en_d    = (period_cnt_d >= CAP_START) && (period_cnt_d <= CAP_LAST);
      cap_first_d = (period_cnt_d == CAP_START);
    end
  end

  assign ld_start_o  = ld_start_q;
  assign cap_en_o    = cap_en_q;
  assign cap_first_o = cap_first_q;
  assign shot_idx_o  = shot_idx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_ld_shot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ld_shot_sequencer
//
// Self-checking bench for ld_shot_sequencer with a small period. It uses a
// behavioural shot model. The model tracks which mode it is in and how far it
// is into the current shot, and it derives every expected output from the
// window arithmetic. Each scenario task also checks pulse counts, spacing and
// durations against figures computed from the parameters.
// -----------------------------------------------------------------------------
module tb_ld_shot_sequencer;

  localparam int PERIOD    = 20;
  localparam int PULSE_W   = 3;
  localparam int CAP_DELAY = 5;
  localparam int CAP_LEN   = 8;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             buf_rdy_i = 1'b0;
  logic [CNT_W-1:0] num_shots_i = '0;
  logic             ld_start_o, cap_en_o, cap_first_o, busy_o, done_o;
  logic [CNT_W-1:0] shot_idx_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ld_shot_sequencer #(
    .PERIOD   (PERIOD),
    .PULSE_W  (PULSE_W),
    .CAP_DELAY(CAP_DELAY),
    .CAP_LEN  (CAP_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .num_shots_i(num_shots_i),
    .buf_rdy_i  (buf_rdy_i),
    .ld_start_o (ld_start_o),
    .cap_en_o   (cap_en_o),
    .cap_first_o(cap_first_o),
    .shot_idx_o (shot_idx_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model. mode: 0 idle, 1 waiting for the buffer, 2 firing.
  // m_t is the number of cycles since the current shot began.
  // ---------------------------------------------------------------------------
  int               m_mode = 0;
  int               m_t = 0;
  logic [CNT_W-1:0] m_idx = '0;
  logic [CNT_W-1:0] m_len = '0;
  logic             m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_t <= 0; m_idx <= '0; m_len <= '0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (abort_i) begin
        m_mode <= 0;
      end else if (m_mode == 0) begin
        if (start_i) begin
          m_len <= num_shots_i; m_idx <= '0; m_t <= 0;
          m_mode <= buf_rdy_i ? 2 : 1;
        end
      end else if (m_mode == 1) begin
        if (buf_rdy_i) begin m_mode <= 2; m_t <= 0; end
      end else if (m_t < PERIOD - 1) begin
        m_t <= m_t + 1;
      end else if (m_len != 0 && m_idx == m_len - 1'b1) begin
        m_mode <= 0; m_done <= 1'b1;
      end else begin
        m_idx <= m_idx + 1'b1; m_t <= 0;
        m_mode <= buf_rdy_i ? 2 : 1;
      end
    end
  end

  logic [CNT_W+4:0] exp_vec, obs_vec;
  assign exp_vec = {(m_mode == 2) && (m_t < PULSE_W),
                    (m_mode == 2) && (m_t >= CAP_DELAY) && (m_t < CAP_DELAY + CAP_LEN),
                    (m_mode == 2) && (m_t == CAP_DELAY),
                    (m_mode != 0),
                    m_done,
                    m_idx};
  assign obs_vec = {ld_start_o, cap_en_o, cap_first_o, busy_o, done_o, shot_idx_o};

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    if (obs_vec !== '0) begin
      errors++;
      $display("FAIL reset_assert: got %h expected 0", obs_vec);
    end
    checks++;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (obs_vec !== '0 || obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_idle c%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      checks++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_burst();
    int rises = 0, last_rise = -1, spacing_bad = 0, dones = 0;
    int busy_cyc = 0, cap_cyc = 0, firsts = 0, first_cap = -1;
    logic prev = 1'b0;
    num_shots_i = 16'd3; buf_rdy_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL burst c%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      checks++;
      if (ld_start_o && !prev) begin
        if (rises > 0 && i - last_rise != PERIOD) spacing_bad++;
        last_rise = i; rises++;
      end
      prev = ld_start_o;
      if (done_o) dones++;
      if (busy_o) busy_cyc++;
      if (cap_en_o) cap_cyc++;
      if (cap_first_o) firsts++;
      if (cap_en_o && first_cap < 0) first_cap = i;
      step();
    end
    if (rises != 3) begin errors++; $display("FAIL burst_rises: got %0d expected 3", rises); end
    checks++;
    if (spacing_bad != 0) begin errors++; $display("FAIL burst_spacing: got %0d bad gaps expected 0", spacing_bad); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL burst_done: got %0d expected 1", dones); end
    checks++;
    if (busy_cyc != 3 * PERIOD) begin errors++; $display("FAIL burst_busy: got %0d expected %0d", busy_cyc, 3 * PERIOD); end
    checks++;
    if (cap_cyc != 3 * CAP_LEN) begin errors++; $display("FAIL burst_cap: got %0d expected %0d", cap_cyc, 3 * CAP_LEN); end
    checks++;
    if (firsts != 3 || first_cap != CAP_DELAY) begin
      errors++;
      $display("FAIL burst_cap_first: got %0d pulses at %0d expected 3 at %0d", firsts, first_cap, CAP_DELAY);
    end
    checks++;
    if (shot_idx_o !== 16'd2) begin errors++; $display("FAIL burst_idx: got %0d expected 2", shot_idx_o); end
    checks++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wait_rdy();
    int ld0 = 0, cap0 = 0, wait_bad = 0, rise1 = -1, dones = 0;
    logic prev = 1'b0;
    num_shots_i = 16'd2; buf_rdy_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 5) buf_rdy_i = 1'b0;   // drop mid-shot: must not truncate shot 0
      if (i == 26) buf_rdy_i = 1'b1;  // seven waiting cycles (20..26)
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL wait_rdy c%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      checks++;
      if (i < PERIOD && ld_start_o) ld0++;
      if (i < PERIOD && cap_en_o) cap0++;
      if (i >= PERIOD && i <= 26 && (ld_start_o || cap_en_o || cap_first_o || !busy_o)) wait_bad++;
      if (i > 0 && ld_start_o && !prev && rise1 < 0) rise1 = i;
      prev = ld_start_o;
      if (done_o) dones++;
      step();
    end
    if (ld0 != PULSE_W || cap0 != CAP_LEN) begin
      errors++;
      $display("FAIL wait_shot0_full: got ld %0d cap %0d expected %0d %0d", ld0, cap0, PULSE_W, CAP_LEN);
    end
    checks++;
    if (wait_bad != 0) begin errors++; $display("FAIL wait_outputs: got %0d bad cycles expected 0", wait_bad); end
    checks++;
    if (rise1 != 27) begin errors++; $display("FAIL wait_resume: got cycle %0d expected 27", rise1); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL wait_done: got %0d expected 1", dones); end
    checks++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ignore();
    int rises = 0, busy_cyc = 0, bad = 0;
    logic prev = 1'b0;
    num_shots_i = 16'd1; buf_rdy_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      start_i = (i == 4 || i == 10);
      if (start_i) num_shots_i = 16'd5;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL ignore_busy c%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      checks++;
      if (ld_start_o && !prev) rises++;
      prev = ld_start_o;
      if (busy_o) busy_cyc++;
      step();
    end
    start_i = 1'b0;
    if (rises != 1 || busy_cyc != PERIOD) begin
      errors++;
      $display("FAIL ignore_burst: got %0d shots %0d busy expected 1 %0d", rises, busy_cyc, PERIOD);
    end
    checks++;
    start_i = 1'b1; abort_i = 1'b1;
    step();
    start_i = 1'b0; abort_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy_o || ld_start_o) bad++;
      step();
    end
    if (bad != 0) begin errors++; $display("FAIL ignore_start_abort: got %0d active cycles expected 0", bad); end
    checks++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_abort_cont();
    int rises = 0, dones = 0, guard = 0;
    logic prev = 1'b0;
    logic [CNT_W-1:0] held;
    num_shots_i = 16'd0; buf_rdy_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL cont c%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      checks++;
      if (ld_start_o && !prev) rises++;
      prev = ld_start_o;
      if (done_o) dones++;
      step();
    end
    while (!cap_en_o && guard < 2 * PERIOD) begin
      if (ld_start_o && !prev) rises++;
      prev = ld_start_o;
      if (done_o) dones++;
      guard++;
      step();
    end
    if (!cap_en_o) begin errors++; $display("FAIL cont_cap_timeout: got no cap_en in %0d cycles", guard); end
    checks++;
    if (rises < 15 || shot_idx_o !== CNT_W'(rises - 1)) begin
      errors++;
      $display("FAIL cont_idx: got idx %0d after %0d shots expected %0d", shot_idx_o, rises, rises - 1);
    end
    checks++;
    held = CNT_W'(rises - 1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    if ({ld_start_o, cap_en_o, cap_first_o, busy_o, done_o} !== 5'b0 || shot_idx_o !== held) begin
      errors++;
      $display("FAIL abort_outputs: got %h expected 0 with idx %0d", obs_vec, held);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      if (done_o) dones++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL abort_hold c%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      checks++;
      step();
    end
    if (dones != 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", dones); end
    checks++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int bad = 0;
    num_shots_i = 16'd2; buf_rdy_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    if (!ld_start_o) begin errors++; $display("FAIL rst_mid_pre: got ld_start 0 expected 1"); end
    checks++;
    #2 rst_n = 1'b0;
    #1;
    if (obs_vec !== '0 || obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL rst_mid_async: got %h expected 0", obs_vec);
    end
    checks++;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (ld_start_o || cap_en_o || busy_o) bad++;
      step();
    end
    if (bad != 0) begin errors++; $display("FAIL rst_mid_idle: got %0d active cycles expected 0", bad); end
    checks++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      start_i   = ($urandom_range(0, 15) == 0);
      abort_i   = ($urandom_range(0, 79) == 0);
      buf_rdy_i = ($urandom_range(0, 3) != 0);
      if (start_i) num_shots_i = CNT_W'($urandom_range(0, 3));
      step();
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random c%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      checks++;
    end
    start_i = 1'b0; abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    step();
    if (busy_o !== 1'b0) begin errors++; $display("FAIL random_end: got busy %b expected 0", busy_o); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_wait_rdy();
    test_ignore();
    test_abort_cont();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
